// File: rtl/track_scroller.sv
// Three-line scrolling track: a ring of NSEG fixed-width columns per line, shifted
// left one pixel per divider step and refilled from an LFSR, with player/renderer lookups.
module track_scroller #(
  parameter int          SEG_W      = 40,
  parameter int          NSEG       = 17,
  parameter int          PLAYER_X   = 100,
  parameter int          SCROLL_DIV = 200000,
  parameter int          SAFE_SEGS  = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [2:0] lines,
  input  logic [9:0] q_x,
  output logic [2:0] q_lines,
  output logic       scroll_tick,
  output logic       seg_tick,
  output logic [15:0] score
);

  localparam int OFF_W  = (SEG_W > 2) ? $clog2(SEG_W) : 1;
  localparam int DIV_W  = $clog2(SCROLL_DIV);
  localparam int SAFE_W = $clog2(SAFE_SEGS + 2);
  localparam int IDX_W  = 11;
  localparam int NQ     = 1023 / SEG_W;

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SEG_W - 1);
  localparam logic [OFF_W:0]   SEG_W_L  = (OFF_W + 1)'(SEG_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam logic [IDX_W-1:0] PX_I     = IDX_W'(PLAYER_X / SEG_W);
  localparam logic [OFF_W-1:0] PX_R     = OFF_W'(PLAYER_X % SEG_W);

  logic [DIV_W-1:0]  div_reg;
  logic [OFF_W-1:0]  offset_reg;
  logic [15:0]       lfsr_reg;
  logic [SAFE_W-1:0] safe_reg;
  logic [15:0]       score_reg;
  logic [2:0]        q_lines_reg;
  logic              scroll_tick_reg;
  logic              seg_tick_reg;
  logic [2:0]        cols_reg [NSEG];

  logic              step;
  logic              shift;
  logic [2:0]        new_col;
  logic [15:0]       lfsr_next;
  logic [NQ-1:0]     q_ge;
  logic [IDX_W-1:0]  q_xi;
  logic [OFF_W-1:0]  q_xr;
  logic [IDX_W-1:0]  player_idx;
  logic [IDX_W-1:0]  q_idx;
  logic [2:0]        q_col;

  // Column index of screen x: x/SEG_W plus one when the remainder and offset overflow a segment.
  function automatic logic [IDX_W-1:0] col_index(input logic [IDX_W-1:0] xi,
                                                 input logic [OFF_W-1:0] xr,
                                                 input logic [OFF_W-1:0] off);
    logic [OFF_W:0] sum;
    sum = {1'b0, xr} + {1'b0, off};
    col_index = (sum >= SEG_W_L) ? xi + IDX_W'(1) : xi;
  endfunction

  assign step      = run && (div_reg == DIV_LAST);
  assign shift     = step && (offset_reg == OFF_LAST);
  assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  always_comb begin
    new_col = 3'b010;
    if (safe_reg == '0 && lfsr_reg[2:0] != 3'b000) begin
      new_col = lfsr_reg[2:0];
    end
  end

  // Thermometer of q_x against every segment boundary; its popcount is q_x / SEG_W.
  genvar gi;
  generate
    for (gi = 0; gi < NQ; gi++) begin : g_qdiv
      assign q_ge[gi] = (q_x >= 10'((gi + 1) * SEG_W));
    end
  endgenerate

  always_comb begin
    q_xi = '0;
    for (int k = 0; k < NQ; k++) begin
      q_xi = q_xi + {{(IDX_W - 1){1'b0}}, q_ge[k]};
    end
    q_xr = OFF_W'(q_x - 10'(q_xi * SEG_W));
  end

  always_comb begin
    player_idx = col_index(PX_I, PX_R, offset_reg);
    q_idx      = col_index(q_xi, q_xr, offset_reg);
    lines      = 3'b000;
    q_col      = 3'b000;
    for (int k = 0; k < NSEG; k++) begin
      if (player_idx == IDX_W'(k)) lines = cols_reg[k];
      if (q_idx == IDX_W'(k))      q_col = cols_reg[k];
    end
  end

  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_col
      if (gi < NSEG - 1) begin : g_mid
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            cols_reg[gi] <= 3'b010;
          end else if (shift) begin
            cols_reg[gi] <= cols_reg[gi + 1];
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            cols_reg[gi] <= 3'b010;
          end else if (shift) begin
            cols_reg[gi] <= new_col;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg         <= '0;
      offset_reg      <= '0;
      lfsr_reg        <= SEED;
      safe_reg        <= SAFE_W'(SAFE_SEGS);
      score_reg       <= '0;
      q_lines_reg     <= 3'b010;
      scroll_tick_reg <= 1'b0;
      seg_tick_reg    <= 1'b0;
    end else begin
      scroll_tick_reg <= step;
      seg_tick_reg    <= shift;
      // Query sees the pre-shift columns even on a shift edge.
      q_lines_reg     <= q_col;
      if (run) begin
        div_reg <= step ? '0 : div_reg + DIV_W'(1);
      end
      if (step) begin
        offset_reg <= (offset_reg == OFF_LAST) ? '0 : offset_reg + OFF_W'(1);
      end
      if (shift) begin
        lfsr_reg <= lfsr_next;
        if (safe_reg != '0) begin
          safe_reg <= safe_reg - SAFE_W'(1);
        end
        if (score_reg != 16'hFFFF) begin
          score_reg <= score_reg + 16'd1;
        end
      end
    end
  end

  assign q_lines     = q_lines_reg;
  assign scroll_tick = scroll_tick_reg;
  assign seg_tick    = seg_tick_reg;
  assign score       = score_reg;

endmodule

// File: doc/track_scroller.md
Name: track_scroller

Overview:
Generates and scrolls the three-line running track. It is the producer of the `lines[2:0]` ground-presence vector that the player-motion block consumes. It also answers registered per-pixel column queries from the VGA renderer and keeps a segments-passed score. The track is a ring of fixed-width segments per line, shifted left as the screen scrolls, and refilled from an LFSR.

Parameters:
SEG_W, 40, segment width in pixels.
NSEG, 17, segments held per line (16 visible plus 1 incoming).
PLAYER_X, 100, screen x of the player's bottom-left corner; must satisfy PLAYER_X < (NSEG-1)*SEG_W.
SCROLL_DIV, 200000, clocks per 1-pixel scroll step; must be ≥ 2.
SAFE_SEGS, 8, number of columns generated after reset that are forced to 3'b010.
SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
run  in  1  1 = scrolling enabled; 0 = freeze all state except the query pipeline
lines  out  3  ground presence at the player column; bit0 = line y120, bit1 = y240, bit2 = y360
q_x  in  10  renderer query x (0..639)
q_lines  out  3  ground presence at column q_x, same bit order as `lines`; registered, 1-cycle latency
scroll_tick  out  1  1-clock pulse on each pixel step
seg_tick  out  1  1-clock pulse on each segment shift
score  out  16  segments passed; saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, asynchronous):
  - All columns = 3'b010; offset = 0; div counter = 0; LFSR = SEED; safe counter = SAFE_SEGS.
  - score = 0; q_lines = 3'b010; scroll_tick = 0; seg_tick = 0.
  - Reset asserted mid-operation returns every register to these values immediately.
- Divider:
  - While run=1, the div counter counts 0..SCROLL_DIV-1.
  - On the terminal count it wraps to 0 and scroll_tick pulses in the same cycle the offset increments.
  - run=0 holds div, offset, columns, LFSR, score and safe counter; scroll_tick = seg_tick = 0.
- Offset: 0..SEG_W-1, incremented on each pixel step.
- Segment shift: a step taken at offset = SEG_W-1 wraps the offset to 0 and shifts in one cycle:
  - column[k] <= column[k+1] for k = 0..NSEG-2;
  - column[NSEG-1] <= new column;
  - seg_tick = 1; score increments (held at FFFF, no wrap).
- New column generation:
  - If safe counter ≠ 0: new column = 3'b010 and the counter decrements.
  - Otherwise new column = LFSR[2:0], except 3'b000 is replaced by 3'b010, so a column is never empty.
  - The LFSR advances only on segment shifts.
  - LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11; shift left; feedback enters bit 0.
- Column lookup, for a screen x: idx = (x + offset) / SEG_W.
  - No runtime divider. Precompute xi = x / SEG_W and xr = x % SEG_W; then idx = xi + ((xr + offset) ≥ SEG_W ? 1 : 0).
  - For q_x, compute xi/xr by comparison or a small constant-divide of a 10-bit value.
  - idx ≥ NSEG gives 3'b000.
- `lines`: combinational lookup at PLAYER_X, updating in the same cycle the offset or columns change.
- `q_lines`: registered lookup of q_x using current-cycle offset and columns; valid one clock after q_x is applied. It updates even when run=0.
- Simultaneous query and shift: q_lines reflects the pre-shift state sampled at that edge.

Test Plan:
1. SCROLL_DIV=4, run=1, release reset:
   - lines = 3'b010 throughout the first SAFE_SEGS shifts.
   - scroll_tick every 4th clock; seg_tick every 160 clocks.
   - score = 8 after 1280 clocks.
2. Reset asserted mid-run (offset=17, score=5):
   - Outputs return to reset values without a clock edge.
   - After release, the first generated column sequence is bit-identical to the post-reset sequence from scenario 1.
3. Generation check across 2000 shifts:
   - No column ever equals 3'b000.
   - After the safe phase, new columns equal the reference LFSR model's [2:0] with the 000→010 substitution.
4. Column boundary, PLAYER_X=100, preload via run:
   - At offset 19, `lines` = column[2]; at offset 20, `lines` = column[3].
   - q_x=639 at offset 39 reads column 16; q_x=639 with offset 0 reads column 15.
5. run toggled 0 for 50 clocks mid-segment:
   - offset, score, LFSR and lines are frozen; no ticks.
   - Resumption continues from the exact div count.
   - q_lines tracks q_x changes with 1-cycle latency while frozen.
6. Score saturation, forced near FFFE:
   - Two more shifts give FFFF.
   - A third shift holds FFFF while seg_tick still pulses.
